serial_adder: RTL

- Bit-serial WIDTH-bit adder built around the team's existing 1-bit `fulladder` cell (ports A, B, Cin, S, Cout).
- Sits directly upstream of that cell: it loads two operands, feeds one bit pair plus the stored carry into the full adder each clock, and captures S/Cout back into registers.
- Produces a WIDTH-bit sum and carry-out after WIDTH clocks, with a start/busy/done handshake.
- Lab-level datapath stage for Icarus simulation.

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder that feeds one bit pair per clock through a 1-bit fulladder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fulladder u_fa (
    .A    (shift_a_q[0]),
    .B    (shift_b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          cnt_d     = '0;
          sum_d     = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // LSB-first: each slice result enters at the top and walks down to its final position.
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        sum_d     = {fa_s, sum_q[WIDTH-1:1]};
        carry_d   = fa_cout;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB slice.
          ovf_d   = fa_cout ^ carry_q;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule
